// File: rtl/mul_pkg.sv
// ---------------------------------------------------------------------------
// mul_pkg
// Shared types and constants for the radix-4 Booth sequential multiplier.
//   mul_state_e  : controller state (IDLE / BUSY / DONE)
//   booth_sel_t  : decoded Booth group {neg, zero, one, two}
//   booth_decode : 3-bit multiplier group -> booth_sel_t
// ---------------------------------------------------------------------------
package mul_pkg;

    localparam int MUL_XLEN  = 64;
    localparam int MUL_STEPS = 33;
    localparam int MUL_CNT_W = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mul_state_e;

    typedef struct packed {
        logic neg;
        logic zero;
        logic one;
        logic two;
    } booth_sel_t;

    // 000/111 -> 0, 001/010 -> +x, 011 -> +2x, 100 -> -2x, 101/110 -> -x
    function automatic booth_sel_t booth_decode(input logic [2:0] g);
        booth_sel_t s;
        s.zero = (g == 3'b000) || (g == 3'b111);
        s.one  = g[1] ^ g[0];
        s.two  = (g == 3'b011) || (g == 3'b100);
        s.neg  = g[2] & ~(g[1] & g[0]);
        return s;
    endfunction

endpackage

// File: rtl/booth_step.sv
// ---------------------------------------------------------------------------
// booth_step
// Combinational radix-4 Booth partial-product generator.
//   grp_i   : 3-bit overlapping multiplier group
//   x_ext_i : sign/zero-extended multiplicand (XW bits, signed)
//   pp_o    : signed partial product, XW+2 bits (room for -2x)
// ---------------------------------------------------------------------------
module booth_step
    import mul_pkg::*;
#(
    parameter int XW = MUL_XLEN + 2
) (
    input  logic        [2:0]    grp_i,
    input  logic signed [XW-1:0] x_ext_i,
    output logic signed [XW+1:0] pp_o
);

    booth_sel_t           sel;
    logic signed [XW+1:0] mag;

    always_comb begin
        sel = booth_decode(grp_i);
        mag = '0;
        if (!sel.zero) begin
            if (sel.two) begin
                mag = {x_ext_i[XW-1], x_ext_i, 1'b0};
            end else if (sel.one) begin
                mag = {{2{x_ext_i[XW-1]}}, x_ext_i};
            end
        end
        pp_o = sel.neg ? -mag : mag;
    end

endmodule

// File: rtl/booth_seq_mul.sv
// ---------------------------------------------------------------------------
// booth_seq_mul
// Multi-cycle XLEN x XLEN radix-4 Booth multiplier, one Booth group per cycle,
// accumulating into a 2*XLEN result register. Independent signedness for
// each operand; the 2*XLEN result is always the exact product.
//
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   mul_valid / mul_ready : request handshake (ready only in IDLE)
//   x_signed, y_signed    : operand signedness
//   x, y                  : multiplicand, multiplier
//   flush                 : abort; returns to IDLE from any state
//   out_valid / out_ready : response handshake (valid only in DONE)
//   result_hi, result_lo  : product bits [2*XLEN-1:XLEN] / [XLEN-1:0]
//
// Build option: define MUL_EARLY_EXIT_EN to finish as soon as every
// remaining Booth group decodes to zero.
// ---------------------------------------------------------------------------
module booth_seq_mul
    import mul_pkg::*;
#(
    parameter int XLEN = MUL_XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            mul_valid,
    output logic            mul_ready,
    input  logic            x_signed,
    input  logic            y_signed,
    input  logic [XLEN-1:0] x,
    input  logic [XLEN-1:0] y,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result_hi,
    output logic [XLEN-1:0] result_lo
);

    localparam int XW    = XLEN + 2;
    localparam int YW    = XLEN + 3;
    localparam int PW    = XLEN + 4;
    localparam int RW    = 2 * XLEN;
    localparam int STEPS = XLEN / 2 + 1;
    localparam logic [MUL_CNT_W-1:0] LAST_CNT = MUL_CNT_W'(STEPS - 1);

    mul_state_e            state_q, state_d;
    logic [MUL_CNT_W-1:0]  cnt_q, cnt_d;
    logic signed [XW-1:0]  x_q, x_d;
    // y_q holds y_ext shifted right by 2*cnt (sign-filled), so the current
    // group is always y_q[2:0].
    logic [YW-1:0]         y_q, y_d;
    logic [RW-1:0]         acc_q, acc_d;

    logic signed [PW-1:0]  pp;
    logic [RW-1:0]         pp_sh;
    logic                  rest_zero;
    logic                  last_step;

    booth_step #(.XW(XW)) u_step (
        .grp_i   (y_q[2:0]),
        .x_ext_i (x_q),
        .pp_o    (pp)
    );

    assign pp_sh = {{(RW - PW){pp[PW-1]}}, pp} << {cnt_q, 1'b0};

    // Remaining groups all decode to zero iff every bit from the low
    // (overlap) bit of the next group upward is identical. That overlap bit
    // is y_q[2], so it must be part of the test.
    assign rest_zero = (&y_q[YW-1:2]) | ~(|y_q[YW-1:2]);

`ifdef MUL_EARLY_EXIT_EN
    assign last_step = (cnt_q == LAST_CNT) || rest_zero;
`else
    assign last_step = (cnt_q == LAST_CNT);
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        acc_d   = acc_q;
        case (state_q)
            ST_IDLE: begin
                if (mul_valid) begin
                    x_d     = x_signed ? {{2{x[XLEN-1]}}, x} : {2'b00, x};
                    y_d     = {(y_signed ? {{2{y[XLEN-1]}}, y} : {2'b00, y}), 1'b0};
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                acc_d = acc_q + pp_sh;
                y_d   = {{2{y_q[YW-1]}}, y_q[YW-1:2]};
                cnt_d = cnt_q + MUL_CNT_W'(1);
                if (last_step) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // flush overrides everything, including an IDLE accept
        if (flush) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            acc_q   <= acc_d;
        end
    end

    assign mul_ready = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign result_hi = acc_q[RW-1:XLEN];
    assign result_lo = acc_q[XLEN-1:0];

endmodule

// File: tb/tb_booth_seq_mul.sv
// Bench for booth_seq_mul. Cycle numbering: the accept edge is edge 0 and
// "cycle n" is the period between edge n-1 and edge n, so without early exit
// out_valid is first seen in cycle 34.
module tb_booth_seq_mul;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mul_valid = 1'b0;
    logic        x_signed = 1'b0;
    logic        y_signed = 1'b0;
    logic [63:0] x = '0;
    logic [63:0] y = '0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b0;
    logic        mul_ready;
    logic        out_valid;
    logic [63:0] result_hi;
    logic [63:0] result_lo;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    booth_seq_mul #(.XLEN(64)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mul_valid (mul_valid),
        .mul_ready (mul_ready),
        .x_signed  (x_signed),
        .y_signed  (y_signed),
        .x         (x),
        .y         (y),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result_hi (result_hi),
        .result_lo (result_lo)
    );

    typedef struct {
        logic        xs;
        logic        ys;
        logic [63:0] xv;
        logic [63:0] yv;
        logic [63:0] hi;
        logic [63:0] lo;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs[NV];

    task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // Issue one request and wait (bounded) for out_valid. Returns the cycle
    // number in which out_valid was first seen, or -1 on timeout. Leaves the
    // DUT in DONE with the bench sitting at a negedge.
    task automatic start_and_wait(input logic xs, input logic ys,
                                  input logic [63:0] xa, input logic [63:0] ya,
                                  output int lat);
        @(negedge clk);
        chk64("ready_before_accept", {63'd0, mul_ready}, 64'd1);
        x_signed  = xs;
        y_signed  = ys;
        x         = xa;
        y         = ya;
        mul_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        mul_valid = 1'b0;
        x         = '0;
        y         = '0;
        chk64("busy_not_ready", {63'd0, mul_ready}, 64'd0);
        lat = -1;
        for (int n = 1; n <= 100 && lat < 0; n++) begin
            if (out_valid) lat = n;
            else @(negedge clk);
        end
        total++;
        if (lat < 0) begin
            bad++;
            $display("FAIL out_valid_timeout: got none want within 100 cycles");
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk64("valid_drop_after_consume", {63'd0, out_valid}, 64'd0);
        chk64("ready_after_consume", {63'd0, mul_ready}, 64'd1);
    endtask

    task automatic watch_no_valid(input string name, input int cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk_int(name, seen, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        logic [63:0] hold_hi;
        logic [63:0] hold_lo;

        vecs[0]  = '{1'b0, 1'b0, 64'd3, 64'd5, 64'd0, 64'd15};
        vecs[1]  = '{1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                     64'hFFFF_FFFF_FFFF_FFFE, 64'h1};
        vecs[2]  = '{1'b1, 1'b1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
                     64'h0, 64'h8000_0000_0000_0000};
        vecs[3]  = '{1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                     64'h0, 64'h1};
        vecs[4]  = '{1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3,
                     64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFA};
        vecs[5]  = '{1'b0, 1'b1, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE,
                     64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFA};
        vecs[6]  = '{1'b0, 1'b0, 64'd7, 64'd6, 64'd0, 64'd42};
        vecs[7]  = '{1'b1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF,
                     64'h3FFF_FFFF_FFFF_FFFF, 64'h1};
        vecs[8]  = '{1'b1, 1'b1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
                     64'h4000_0000_0000_0000, 64'h0};
        vecs[9]  = '{1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                     64'hFFFF_FFFF_FFFF_FFFF, 64'h1};
        vecs[10] = '{1'b0, 1'b0, 64'hFEDC_BA98_7654_3210, 64'h100,
                     64'hFE, 64'hDCBA_9876_5432_1000};
        vecs[11] = '{1'b1, 1'b1, 64'h0, 64'h8000_0000_0000_0000, 64'h0, 64'h0};
        vecs[12] = '{1'b0, 1'b0, 64'h8000_0000_0000_0000, 64'd2, 64'h1, 64'h0};
        vecs[13] = '{1'b1, 1'b1, 64'h8000_0000_0000_0000, 64'd2,
                     64'hFFFF_FFFF_FFFF_FFFF, 64'h0};
        vecs[14] = '{1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5,
                     64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFF1};

        // reset state
        repeat (3) @(negedge clk);
        chk64("rst_ready", {63'd0, mul_ready}, 64'd1);
        chk64("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk64("rst_hi", result_hi, 64'd0);
        chk64("rst_lo", result_lo, 64'd0);
        rst_n = 1'b1;

        // table-driven products
        for (int i = 0; i < NV; i++) begin
            start_and_wait(vecs[i].xs, vecs[i].ys, vecs[i].xv, vecs[i].yv, lat);
            chk64($sformatf("vec%0d_hi", i), result_hi, vecs[i].hi);
            chk64($sformatf("vec%0d_lo", i), result_lo, vecs[i].lo);
`ifdef MUL_EARLY_EXIT_EN
            total++;
            if (lat < 2 || lat > 34) begin
                bad++;
                $display("FAIL vec%0d_latency: got %0d want 2..34", i, lat);
            end
`else
            chk_int($sformatf("vec%0d_latency", i), lat, 34);
`endif
            consume();
        end

        // 3x5 latency (early exit after two steps when enabled)
        start_and_wait(1'b0, 1'b0, 64'd3, 64'd5, lat);
`ifdef MUL_EARLY_EXIT_EN
        chk_int("lat_3x5", lat, 3);
`else
        chk_int("lat_3x5", lat, 34);
`endif
        chk64("lat_3x5_lo", result_lo, 64'd15);
        consume();

        // max x max never exits early: the top group is 001
        start_and_wait(1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, lat);
        chk_int("lat_maxmax", lat, 34);
        chk64("lat_maxmax_hi", result_hi, 64'hFFFF_FFFF_FFFF_FFFE);
        consume();

        // flush in BUSY cycle 10
        @(negedge clk);
        x = 64'd1234; y = 64'hFFFF_0000_FFFF_0000; mul_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        mul_valid = 1'b0;
        repeat (9) @(negedge clk);
        chk64("flush_busy_before", {63'd0, mul_ready}, 64'd0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk64("flush_ready", {63'd0, mul_ready}, 64'd1);
        chk64("flush_out_valid", {63'd0, out_valid}, 64'd0);
        watch_no_valid("flush_no_valid", 40);
        start_and_wait(1'b0, 1'b0, 64'd7, 64'd6, lat);
        chk64("after_flush_hi", result_hi, 64'd0);
        chk64("after_flush_lo", result_lo, 64'd42);

        // hold in DONE with out_ready low for 5 cycles
        hold_hi = result_hi;
        hold_lo = result_lo;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk64("hold_valid", {63'd0, out_valid}, 64'd1);
            chk64("hold_ready", {63'd0, mul_ready}, 64'd0);
            chk64("hold_hi", result_hi, hold_hi);
            chk64("hold_lo", result_lo, hold_lo);
        end

        // a request in DONE alongside out_ready must not be accepted
        x = 64'd9; y = 64'd9; mul_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        mul_valid = 1'b0; out_ready = 1'b0;
        chk64("done_no_accept_ready", {63'd0, mul_ready}, 64'd1);
        chk64("done_no_accept_valid", {63'd0, out_valid}, 64'd0);
        @(negedge clk);
        chk64("done_no_accept_still_idle", {63'd0, mul_ready}, 64'd1);

        // mul_valid together with flush in IDLE is dropped
        x = 64'd2; y = 64'd2; mul_valid = 1'b1; flush = 1'b1;
        @(negedge clk);
        mul_valid = 1'b0; flush = 1'b0;
        chk64("idle_flush_drop_ready", {63'd0, mul_ready}, 64'd1);
        watch_no_valid("idle_flush_no_valid", 40);

        // asynchronous reset mid-operation
        @(negedge clk);
        x = 64'hFFFF_FFFF_FFFF_FFFF; y = 64'd3; mul_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        mul_valid = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk64("midrst_ready", {63'd0, mul_ready}, 64'd1);
        chk64("midrst_valid", {63'd0, out_valid}, 64'd0);
        chk64("midrst_hi", result_hi, 64'd0);
        chk64("midrst_lo", result_lo, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        watch_no_valid("midrst_no_valid", 40);

        // normal operation after reset
        start_and_wait(1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, lat);
        chk64("post_rst_hi", result_hi, 64'hFFFF_FFFF_FFFF_FFFF);
        chk64("post_rst_lo", result_lo, 64'hFFFF_FFFF_FFFF_FFFA);
        consume();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
